// File: rtl/kypd_scanner.sv
// kypd_scanner: matrix keypad scanner with debounce, ghost rejection and event FIFO.
// Define KYPD_AUTOREPEAT_EN to add held-key auto-repeat events.
module kypd_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE = 10,
  localparam int CW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_n,
  input  logic [ROWS-1:0] row_n,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow
);
  localparam int XW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
  logic            act_q;
  logic [XW-1:0]   col_q;
  logic [SW-1:0]   div_q;
  logic [ROWS-1:0] s1_q, s2_q;
  logic [1:0]      acc_n_q, hits;
  logic [CW-1:0]   acc_k_q, code;
  logic            cand_key_q, held_q;
  logic [CW-1:0]   cand_code_q, held_code_q;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [CW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_q, rd_q;
  logic            ovf_q;
  logic dwell_end, frame_end, frm_key, frm_multi, same, settle, press;
  logic push, pop, full, empty, wr_en;
  logic [CW-1:0] push_code;
  assign dwell_end = act_q && div_q == SW'(SCAN_DIV-1);
  assign frame_end = dwell_end && col_q == XW'(COLS-1);
  // Hit count saturates at 2: anything beyond one contact is a ghost-prone MULTI frame.
  always_comb begin
    hits = acc_n_q;
    code = acc_k_q;
    for (int r = 0; r < ROWS; r++)
      if (!s2_q[r]) begin
        hits = (hits == 2'd2) ? 2'd2 : hits + 2'd1;
        code = CW'(r*COLS + int'(col_q));
      end
  end
  assign frm_multi = hits == 2'd2;
  assign frm_key   = hits == 2'd1;
  assign same      = (frm_key == cand_key_q) && (!frm_key || code == cand_code_q);
  assign dcnt_d    = frm_multi ? 4'd0 : same ? (dcnt_q == DB ? dcnt_q : dcnt_q + 4'd1) : 4'd1;
  assign settle    = frame_end && !frm_multi && dcnt_d == DB;
  assign press     = settle && frm_key && (!held_q || code != held_code_q);
`ifdef KYPD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_first_q, change, rep_hit;
  assign change    = settle && (frm_key != held_q || (frm_key && code != held_code_q));
  assign rep_cnt_d = rep_cnt_q + RW'(1);
  assign rep_hit   = frame_end && held_q && !change &&
                     rep_cnt_d == (rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE));
  assign push      = press || rep_hit;
  assign push_code = press ? code : held_code_q;
  always_ff @(posedge clk)
    if (!rst_n || change) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (frame_end && held_q) begin
      rep_cnt_q   <= rep_hit ? '0 : rep_cnt_d;
      rep_first_q <= rep_first_q && !rep_hit;
    end
`else
  assign push      = press;
  assign push_code = code;
`endif
  assign empty     = wr_q == rd_q;
  assign full      = (wr_q ^ rd_q) == {1'b1, AW'(0)};
  assign pop       = !empty && key_ready;
  assign wr_en     = push && (!full || pop);
  assign col_n     = act_q ? ~(COLS'(1) << col_q) : '1;
  assign key_valid = !empty;
  assign key_code  = mem_q[rd_q[AW-1:0]];
  assign key_held  = held_q;
  assign overflow  = ovf_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      act_q       <= 1'b0;
      col_q       <= '0;
      div_q       <= '0;
      s1_q        <= '1;
      s2_q        <= '1;
      acc_n_q     <= '0;
      acc_k_q     <= '0;
      cand_key_q  <= 1'b0;
      cand_code_q <= '0;
      dcnt_q      <= '0;
      held_q      <= 1'b0;
      held_code_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      act_q <= 1'b1;
      s1_q  <= row_n;
      s2_q  <= s1_q;
      if (act_q) div_q <= dwell_end ? '0 : div_q + SW'(1);
      if (dwell_end) begin
        col_q   <= frame_end ? '0 : col_q + XW'(1);
        acc_n_q <= frame_end ? 2'd0 : hits;
        acc_k_q <= code;
      end
      if (frame_end) begin
        dcnt_q <= dcnt_d;
        if (!frm_multi && !same) begin
          cand_key_q  <= frm_key;
          cand_code_q <= code;
        end
      end
      if (settle) begin
        held_q      <= frm_key;
        held_code_q <= code;
      end
      if (wr_en) begin
        mem_q[wr_q[AW-1:0]] <= push_code;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
endmodule
